// File: rtl/axis_beam_combiner.sv
// axis_beam_combiner: joins CHANNELS weighted complex AXI streams and sums
// them sample-by-sample with saturation into one paired real/imag beam.
// Every input beat is taken atomically across all 2*CHANNELS streams.
// The two output streams then drain independently of each other.
module axis_beam_combiner #(
  parameter int CHANNELS     = 2,
  parameter int SDATA_WIDTH  = 128,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SAMPLES      = SDATA_WIDTH / SAMPLE_WIDTH,
  parameter int MDATA_WIDTH  = SAMPLES * SAMPLE_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             s_axis_real_tvalid,
  output logic [CHANNELS-1:0]             s_axis_real_tready,
  input  logic [CHANNELS*SDATA_WIDTH-1:0] s_axis_real_tdata,
  input  logic [CHANNELS-1:0]             s_axis_real_tlast,
  input  logic [CHANNELS-1:0]             s_axis_imag_tvalid,
  output logic [CHANNELS-1:0]             s_axis_imag_tready,
  input  logic [CHANNELS*SDATA_WIDTH-1:0] s_axis_imag_tdata,
  input  logic [CHANNELS-1:0]             s_axis_imag_tlast,
  output logic [MDATA_WIDTH-1:0]          m_axis_real_s2mm_tdata,
  output logic                            m_axis_real_s2mm_tvalid,
  input  logic                            m_axis_real_s2mm_tready,
  output logic                            m_axis_real_s2mm_tlast,
  output logic [MDATA_WIDTH-1:0]          m_axis_imag_s2mm_tdata,
  output logic                            m_axis_imag_s2mm_tvalid,
  input  logic                            m_axis_imag_s2mm_tready,
  output logic                            m_axis_imag_s2mm_tlast,
  input  logic                            err_clear,
  output logic                            tlast_error,
  output logic                            sat_pulse
);

  // Two guard bits hold the sum of up to four full-scale samples exactly.
  localparam int SUM_W = SAMPLE_WIDTH + 2;

  // A sum fits the output width only when its top three bits all agree.
  function automatic logic is_clamped(input logic signed [SUM_W-1:0] sum);
    logic [2:0] top;
    top = sum[SUM_W-1:SAMPLE_WIDTH-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic signed [SAMPLE_WIDTH-1:0] saturate(input logic signed [SUM_W-1:0] sum);
    if (!is_clamped(sum))
      return sum[SAMPLE_WIDTH-1:0];
    else if (sum[SUM_W-1])
      return {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  endfunction

  logic                    real_vld_p1, imag_vld_p1;
  logic [MDATA_WIDTH-1:0]  real_data_p1, imag_data_p1;
  logic                    last_p1;
  logic                    sat_p1;
  logic                    err_p1;

  logic                    all_valid, can_load, accept, last_mismatch;
  logic [2*CHANNELS-1:0]   last_bits;
  logic [MDATA_WIDTH-1:0]  real_sat, imag_sat;
  logic                    any_clamp;
  logic signed [SUM_W-1:0] real_acc, imag_acc;

  assign all_valid     = (&s_axis_real_tvalid) && (&s_axis_imag_tvalid);
  assign can_load      = (!real_vld_p1 || m_axis_real_s2mm_tready) &&
                         (!imag_vld_p1 || m_axis_imag_s2mm_tready);
  assign accept        = all_valid && can_load;
  assign last_bits     = {s_axis_real_tlast, s_axis_imag_tlast};
  assign last_mismatch = !((&last_bits) || !(|last_bits));

  // Ready depends on valid (never the reverse) so a beat is taken on all streams at once.
  assign s_axis_real_tready = {CHANNELS{accept && !reset}};
  assign s_axis_imag_tready = {CHANNELS{accept && !reset}};

  // Saturating per-sample sum across channels for both parts of the beat.
  always_comb begin
    real_sat  = '0;
    imag_sat  = '0;
    any_clamp = 1'b0;
    real_acc  = '0;
    imag_acc  = '0;
    for (int s = 0; s < SAMPLES; s++) begin
      real_acc = '0;
      imag_acc = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        real_acc = real_acc + SUM_W'($signed(s_axis_real_tdata[c*SDATA_WIDTH + s*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
        imag_acc = imag_acc + SUM_W'($signed(s_axis_imag_tdata[c*SDATA_WIDTH + s*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
      end
      real_sat[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] = saturate(real_acc);
      imag_sat[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] = saturate(imag_acc);
      any_clamp = any_clamp | is_clamped(real_acc) | is_clamped(imag_acc);
    end
  end

  // Output stage: load both streams on accept, drop each valid on its own handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      real_vld_p1  <= 1'b0;
      imag_vld_p1  <= 1'b0;
      real_data_p1 <= '0;
      imag_data_p1 <= '0;
      last_p1      <= 1'b0;
      sat_p1       <= 1'b0;
      err_p1       <= 1'b0;
    end else begin
      sat_p1 <= accept && any_clamp;
      if (accept) begin
        real_data_p1 <= real_sat;
        imag_data_p1 <= imag_sat;
        last_p1      <= s_axis_real_tlast[0];
        real_vld_p1  <= 1'b1;
        imag_vld_p1  <= 1'b1;
      end else begin
        if (real_vld_p1 && m_axis_real_s2mm_tready) real_vld_p1 <= 1'b0;
        if (imag_vld_p1 && m_axis_imag_s2mm_tready) imag_vld_p1 <= 1'b0;
      end
      // A fresh mismatch outranks a simultaneous clear.
      if (accept && last_mismatch) err_p1 <= 1'b1;
      else if (err_clear)          err_p1 <= 1'b0;
    end
  end

  assign m_axis_real_s2mm_tdata  = real_data_p1;
  assign m_axis_real_s2mm_tvalid = real_vld_p1;
  assign m_axis_real_s2mm_tlast  = last_p1;
  assign m_axis_imag_s2mm_tdata  = imag_data_p1;
  assign m_axis_imag_s2mm_tvalid = imag_vld_p1;
  assign m_axis_imag_s2mm_tlast  = last_p1;
  assign tlast_error             = err_p1;
  assign sat_pulse               = sat_p1;

endmodule

// File: tb/tb_axis_beam_combiner.sv
// Testbench for axis_beam_combiner: directed scenarios plus a randomized
// burst, all scored against a queue-based reference of the beam sums.
module tb_axis_beam_combiner;

  localparam int CH = 2;
  localparam int W  = 128;
  localparam int W2 = CH * W;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic          clock;
  logic          rst, eclr, m_rr, m_ir;
  logic [CH-1:0] s_rv, s_iv, s_rl, s_il;
  logic [W2-1:0] s_rd, s_id;
  logic [CH-1:0] s_rr, s_ir;
  logic [W-1:0]  m_rd, m_id;
  logic          m_rv, m_iv, m_rl, m_il, err, sat;

  int n_chk = 0;
  int n_fail = 0;
  int n_in = 0, n_out_r = 0, n_out_i = 0;
  bit mon_en = 0;
  bit exp_sat = 0, exp_err = 0;
  beat_t rq[$];
  beat_t iq[$];

  axis_beam_combiner #(.CHANNELS(CH)) dut (
    .clock(clock), .reset(rst),
    .s_axis_real_tvalid(s_rv), .s_axis_real_tready(s_rr),
    .s_axis_real_tdata(s_rd),  .s_axis_real_tlast(s_rl),
    .s_axis_imag_tvalid(s_iv), .s_axis_imag_tready(s_ir),
    .s_axis_imag_tdata(s_id),  .s_axis_imag_tlast(s_il),
    .m_axis_real_s2mm_tdata(m_rd), .m_axis_real_s2mm_tvalid(m_rv),
    .m_axis_real_s2mm_tready(m_rr), .m_axis_real_s2mm_tlast(m_rl),
    .m_axis_imag_s2mm_tdata(m_id), .m_axis_imag_s2mm_tvalid(m_iv),
    .m_axis_imag_s2mm_tready(m_ir), .m_axis_imag_s2mm_tlast(m_il),
    .err_clear(eclr), .tlast_error(err), .sat_pulse(sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference beam: integer sum per sample, clamped to the 16-bit range.
  function automatic void model(input logic [W2-1:0] d, output logic [W-1:0] o, output bit clamped);
    int sum;
    clamped = 0;
    o = '0;
    for (int s = 0; s < W / 16; s++) begin
      sum = 0;
      for (int c = 0; c < CH; c++) sum += $signed(d[c*W + s*16 +: 16]);
      if (sum > 32767) begin sum = 32767; clamped = 1; end
      if (sum < -32768) begin sum = -32768; clamped = 1; end
      o[s*16 +: 16] = sum[15:0];
    end
  endfunction

  function automatic logic [W2-1:0] rnd();
    logic [W2-1:0] r;
    for (int k = 0; k < W2 / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one beat; optionally hold the last imag channel back for skew cycles.
  task automatic send(input logic [W2-1:0] rd, input logic [W2-1:0] id,
                      input logic [CH-1:0] rl, input logic [CH-1:0] il, input int skew);
    bit got;
    got = 0;
    s_rd = rd; s_id = id; s_rl = rl; s_il = il;
    s_rv = '1; s_iv = '1;
    s_iv[CH-1] = (skew == 0);
    for (int k = 0; k < skew; k++) begin
      @(negedge clock);
      chk("skew_tready", W'(s_rr), W'(0));
      tick();
    end
    s_iv[CH-1] = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clock);
      got = s_rr[0];
      tick();
    end
    chk("send_timeout", W'(got), W'(1));
    s_rv = '0; s_iv = '0;
  endtask

  // Scoreboard: each output stream is a queue of pending beats.
  always @(negedge clock) begin
    bit acc, rc, ic, mism;
    logic [W-1:0] ro, io;
    if (mon_en) begin
      rc = 0; ic = 0;
      acc = (&s_rv) && (&s_iv) && (rq.size() == 0 || m_rr) && (iq.size() == 0 || m_ir) && !rst;
      chk("s_real_tready", W'(s_rr), W'({CH{acc}}));
      chk("s_imag_tready", W'(s_ir), W'({CH{acc}}));
      chk("m_real_tvalid", W'(m_rv), W'(rq.size() != 0));
      chk("m_imag_tvalid", W'(m_iv), W'(iq.size() != 0));
      if (rq.size() != 0) begin
        chk("m_real_tdata", m_rd, rq[0].d);
        chk("m_real_tlast", W'(m_rl), W'(rq[0].l));
      end
      if (iq.size() != 0) begin
        chk("m_imag_tdata", m_id, iq[0].d);
        chk("m_imag_tlast", W'(m_il), W'(iq[0].l));
      end
      chk("sat_pulse", W'(sat), W'(exp_sat));
      chk("tlast_error", W'(err), W'(exp_err));
      if (rst) begin
        rq.delete(); iq.delete();
        exp_sat = 0; exp_err = 0;
      end else begin
        if (rq.size() != 0 && m_rr) begin void'(rq.pop_front()); n_out_r++; end
        if (iq.size() != 0 && m_ir) begin void'(iq.pop_front()); n_out_i++; end
        if (acc) begin
          model(s_rd, ro, rc);
          model(s_id, io, ic);
          rq.push_back('{ro, s_rl[0]});
          iq.push_back('{io, s_rl[0]});
          n_in++;
        end
        exp_sat = acc && (rc || ic);
        mism = !((&{s_rl, s_il}) || !(|{s_rl, s_il}));
        if (acc && mism) exp_err = 1;
        else if (eclr)   exp_err = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W2-1:0] ar, ai, br, bi, d;
    logic [W-1:0]  e;
    bit            dummy;
    bit            burst_done;
    int            base_in, base_out;
    rst = 1; eclr = 0; m_rr = 0; m_ir = 0;
    s_rv = '0; s_iv = '0; s_rl = '0; s_il = '0; s_rd = '0; s_id = '0;
    burst_done = 0;

    // Reset state
    @(posedge clock); #1;
    mon_en = 1;
    tick();
    @(negedge clock);
    chk("rst_rvalid", W'(m_rv), W'(0));
    chk("rst_ivalid", W'(m_iv), W'(0));
    chk("rst_rdata", m_rd, W'(0));
    chk("rst_idata", m_id, W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_sat", W'(sat), W'(0));
    tick();
    rst = 0; m_rr = 1; m_ir = 1;
    tick();

    // Basic sum
    send({{8{16'h0200}}, {8{16'h0100}}}, {16{16'hFFFF}}, '0, '0, 0);
    @(negedge clock);
    chk("basic_rvalid", W'(m_rv), W'(1));
    chk("basic_real", m_rd, {8{16'h0300}});
    chk("basic_imag", m_id, {8{16'hFFFE}});
    chk("basic_sat", W'(sat), W'(0));
    tick();

    // Saturation
    d = '0; d[15:0] = 16'h7000; d[W +: 16] = 16'h7000; ar = d;
    d = '0; d[63:48] = 16'h8000; d[W + 48 +: 16] = 16'h8001; ai = d;
    send(ar, ai, '0, '0, 0);
    @(negedge clock);
    chk("sat_real0", W'(m_rd[15:0]), W'(16'h7FFF));
    chk("sat_imag3", W'(m_id[63:48]), W'(16'h8000));
    chk("sat_pulse_on", W'(sat), W'(1));
    tick();
    @(negedge clock);
    chk("sat_pulse_off", W'(sat), W'(0));
    tick();

    // Skewed imag valid on the last channel
    send(rnd(), rnd(), '0, '0, 3);
    @(negedge clock);
    chk("skew_outvalid", W'(m_rv), W'(1));
    tick();

    // Split backpressure: imag stalls while real drains
    m_rr = 1; m_ir = 0;
    ar = rnd(); ai = rnd();
    send(ar, ai, '0, '0, 0);
    model(ai, e, dummy);
    br = rnd(); bi = rnd();
    s_rd = br; s_id = bi; s_rl = '0; s_il = '0; s_rv = '1; s_iv = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("split_rvalid", W'(m_rv), W'(k == 0));
      chk("split_ivalid", W'(m_iv), W'(1));
      chk("split_idata", m_id, e);
      chk("split_tready", W'(s_rr), W'(0));
      tick();
    end
    m_ir = 1;
    send(br, bi, '0, '0, 0);
    model(br, e, dummy);
    @(negedge clock);
    chk("split_next", m_rd, e);
    tick();
    tick();

    // Randomized burst with random readies and skew
    base_in = n_in; base_out = n_out_r;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(rnd(), rnd(), {CH{1'b1}} & {CH{i % 8 == 7}}, {CH{1'b1}} & {CH{i % 8 == 7}}, $urandom_range(0, 2));
        end
        burst_done = 1;
      end
      begin
        while (!burst_done) begin
          m_rr = 1'($urandom_range(0, 1));
          m_ir = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    m_rr = 1; m_ir = 1;
    repeat (4) tick();
    chk("burst_in", W'(n_in - base_in), W'(64));
    chk("burst_out_r", W'(n_out_r - base_out), W'(64));
    chk("burst_out_i", W'(n_out_i - n_out_r), W'(0));

    // tlast mismatch within an 8-beat packet
    for (int b = 1; b <= 8; b++) begin
      send(rnd(), rnd(), (b == 7) ? 2'b10 : (b == 8) ? 2'b01 : 2'b00,
           (b == 8) ? 2'b11 : 2'b00, 0);
      @(negedge clock);
      if (b == 7) begin
        chk("tl_err_set", W'(err), W'(1));
        chk("tl_last7", W'(m_rl), W'(0));
      end
      if (b == 8) chk("tl_last8", W'(m_il), W'(1));
      tick();
    end
    eclr = 1;
    tick();
    eclr = 0;
    @(negedge clock);
    chk("tl_err_clr", W'(err), W'(0));
    tick();

    // Reset with a stalled output beat
    m_rr = 0; m_ir = 0;
    send(rnd(), rnd(), 2'b01, 2'b00, 0);
    s_rd = rnd(); s_id = rnd(); s_rv = '1; s_iv = '1;
    @(negedge clock);
    chk("stall_err", W'(err), W'(1));
    chk("stall_valid", W'(m_rv), W'(1));
    tick();
    rst = 1;
    @(negedge clock);
    chk("rst_tready", W'(s_rr), W'(0));
    tick();
    @(negedge clock);
    chk("rst2_rvalid", W'(m_rv), W'(0));
    chk("rst2_ivalid", W'(m_iv), W'(0));
    chk("rst2_rdata", m_rd, W'(0));
    chk("rst2_idata", m_id, W'(0));
    chk("rst2_err", W'(err), W'(0));
    tick();
    rst = 0; s_rv = '0; s_iv = '0; m_rr = 1; m_ir = 1;
    tick();
    ar = rnd(); ai = rnd();
    send(ar, ai, '0, '0, 0);
    model(ai, e, dummy);
    @(negedge clock);
    chk("resume_imag", m_id, e);
    tick();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
